// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// requester identifiers and the hard-wired zero register index.
package regfile_wr_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_wr_arbiter_slot.sv
// One-entry holding slot for a writeback request: a load in the same edge as a
// clear wins, so a granted slot can be refilled without a bubble.
module regfile_wr_arbiter_slot
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] rd_o,
    output logic [DATA_W-1:0] data_o
);

    logic              full_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            full_q <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (load_i) begin
            full_q <= 1'b1;
            rd_q   <= rd_i;
            data_q <= data_i;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign rd_o   = rd_q;
    assign data_o = data_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths,
// dropping $0/overflow writes and exporting a pending-write scoreboard.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FIXED_PRI = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Run,
    input  logic              Alu_Valid,
    output logic              Alu_Ready,
    input  logic [ADDR_W-1:0] Alu_Rd,
    input  logic [DATA_W-1:0] Alu_Data,
    input  logic              Alu_Ovf,
    input  logic              Mem_Valid,
    output logic              Mem_Ready,
    input  logic [ADDR_W-1:0] Mem_Rd,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic              RegWr,
    output logic [ADDR_W-1:0] Rw,
    output logic [DATA_W-1:0] busW,
    output logic [31:0]       Pend,
    output logic [CNT_W-1:0]  DropCnt
);

    logic              aluFull, memFull, bothFull;
    logic [ADDR_W-1:0] aluRd, memRd;
    logic [DATA_W-1:0] aluData, memData;
    logic              grantAlu, grantMem;
    logic              aluAccept, memAccept, aluDrop, memDrop, aluLoad, memLoad;
    logic              aluFullNext, memFullNext;
    logic [CNT_W:0]    dropSum;

    req_e              ptr_q, ptr_d;
    logic              memOlder_q, memOlder_d;
    logic              regWr_q;
    logic [ADDR_W-1:0] rw_q;
    logic [DATA_W-1:0] busW_q;
    logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;

    regfile_wr_arbiter_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_aluSlot (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .load_i (aluLoad),
        .clear_i(grantAlu),
        .rd_i   (Alu_Rd),
        .data_i (Alu_Data),
        .full_o (aluFull),
        .rd_o   (aluRd),
        .data_o (aluData)
    );

    regfile_wr_arbiter_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_memSlot (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .load_i (memLoad),
        .clear_i(grantMem),
        .rd_i   (Mem_Rd),
        .data_i (Mem_Data),
        .full_o (memFull),
        .rd_o   (memRd),
        .data_o (memData)
    );

    assign bothFull = aluFull & memFull;

    // Equal destinations must retire oldest-first to keep write-after-write order.
    always_comb begin
        grantAlu = 1'b0;
        grantMem = 1'b0;
        ptr_d    = ptr_q;
        if (Run) begin
            if (bothFull) begin
                if (aluRd == memRd)
                    grantMem = memOlder_q;
                else if (FIXED_PRI != 0)
                    grantMem = 1'b1;
                else
                    grantMem = (ptr_q == REQ_MEM);
                grantAlu = ~grantMem;
                ptr_d    = grantMem ? REQ_ALU : REQ_MEM;
            end else begin
                grantAlu = aluFull;
                grantMem = memFull;
            end
        end
    end

    assign Alu_Ready = ~aluFull | grantAlu;
    assign Mem_Ready = ~memFull | grantMem;
    assign aluAccept = Alu_Valid & Alu_Ready;
    assign memAccept = Mem_Valid & Mem_Ready;
    assign aluDrop   = aluAccept & ((Alu_Rd == ADDR_W'(REG_ZERO)) | Alu_Ovf);
    assign memDrop   = memAccept & (Mem_Rd == ADDR_W'(REG_ZERO));
    assign aluLoad   = aluAccept & ~aluDrop;
    assign memLoad   = memAccept & ~memDrop;

    // memOlder_q is only meaningful while both slots hold a request.
    always_comb begin
        aluFullNext = aluLoad | (aluFull & ~grantAlu);
        memFullNext = memLoad | (memFull & ~grantMem);
        memOlder_d  = 1'b0;
        if (aluFullNext && memFullNext) begin
            if (memLoad)
                memOlder_d = 1'b0;
            else if (aluLoad)
                memOlder_d = 1'b1;
            else
                memOlder_d = memOlder_q;
        end
    end

    assign dropSum   = {1'b0, dropCnt_q} + (CNT_W+1)'(aluDrop) + (CNT_W+1)'(memDrop);
    assign dropCnt_d = dropSum[CNT_W] ? {CNT_W{1'b1}} : dropSum[CNT_W-1:0];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q      <= REQ_ALU;
            memOlder_q <= 1'b0;
            regWr_q    <= 1'b0;
            rw_q       <= '0;
            busW_q     <= '0;
            dropCnt_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            memOlder_q <= memOlder_d;
            regWr_q    <= grantAlu | grantMem;
            dropCnt_q  <= dropCnt_d;
            if (grantAlu) begin
                rw_q   <= aluRd;
                busW_q <= aluData;
            end else if (grantMem) begin
                rw_q   <= memRd;
                busW_q <= memData;
            end
        end
    end

    // Built from registered state only so decode stalls never loop back through Valid.
    always_comb begin
        Pend = '0;
        for (int i = 1; i < 32; i++) begin
            Pend[i] = (aluFull & (aluRd == ADDR_W'(i))) |
                      (memFull & (memRd == ADDR_W'(i))) |
                      (regWr_q & (rw_q  == ADDR_W'(i)));
        end
    end

    assign RegWr   = regWr_q;
    assign Rw      = rw_q;
    assign busW    = busW_q;
    assign DropCnt = dropCnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a slot/timestamp reference model.
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Run = 1'b1;
    logic          Alu_Valid = 1'b0;
    logic [AW-1:0] Alu_Rd = '0;
    logic [DW-1:0] Alu_Data = '0;
    logic          Alu_Ovf = 1'b0;
    logic          Mem_Valid = 1'b0;
    logic [AW-1:0] Mem_Rd = '0;
    logic [DW-1:0] Mem_Data = '0;
    logic          Alu_Ready, Mem_Ready, RegWr;
    logic [AW-1:0] Rw;
    logic [DW-1:0] busW;
    logic [31:0]   Pend;
    logic [CW-1:0] DropCnt;

    regfile_wr_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run),
        .Alu_Valid(Alu_Valid), .Alu_Ready(Alu_Ready), .Alu_Rd(Alu_Rd),
        .Alu_Data(Alu_Data), .Alu_Ovf(Alu_Ovf),
        .Mem_Valid(Mem_Valid), .Mem_Ready(Mem_Ready), .Mem_Rd(Mem_Rd), .Mem_Data(Mem_Data),
        .RegWr(RegWr), .Rw(Rw), .busW(busW), .Pend(Pend), .DropCnt(DropCnt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;

    // Reference model: slot 0 = ALU, slot 1 = Mem, each stamped with its load cycle.
    bit          mValid [2];
    logic [4:0]  mRd    [2];
    logic [31:0] mData  [2];
    int          mStamp [2];
    int          mCycle;
    int          mLastWin;
    bit          mRegWr;
    logic [4:0]  mRw;
    logic [31:0] mBusW;
    int          mDrops;
    bit          aluTook, memTook;
    logic [31:0] rf [32];

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mValid[k] = 1'b0; mRd[k] = '0; mData[k] = '0; mStamp[k] = 0;
        end
        mCycle = 0; mLastWin = 1;
        mRegWr = 1'b0; mRw = '0; mBusW = '0; mDrops = 0;
        aluTook = 1'b0; memTook = 1'b0;
    endtask

    function automatic int modelWinner();
        if (!Run) return -1;
        if (mValid[0] && mValid[1]) begin
            if (mRd[0] == mRd[1]) return (mStamp[1] < mStamp[0]) ? 1 : 0;
            return 1 - mLastWin;
        end
        if (mValid[0]) return 0;
        if (mValid[1]) return 1;
        return -1;
    endfunction

    task automatic modelStep();
        int w;
        int drops;
        bit r0, r1, both;
        if (!Reset_n) begin
            modelReset();
            return;
        end
        w    = modelWinner();
        both = mValid[0] && mValid[1];
        r0   = !mValid[0] || (w == 0);
        r1   = !mValid[1] || (w == 1);
        mRegWr = (w >= 0);
        if (w >= 0) begin
            mRw = mRd[w]; mBusW = mData[w]; mValid[w] = 1'b0;
            if (both) mLastWin = w;
        end
        aluTook = Alu_Valid && r0;
        memTook = Mem_Valid && r1;
        drops = 0;
        if (aluTook) begin
            if (Alu_Rd == 0 || Alu_Ovf) drops++;
            else begin
                mValid[0] = 1'b1; mRd[0] = Alu_Rd; mData[0] = Alu_Data; mStamp[0] = mCycle;
            end
        end
        if (memTook) begin
            if (Mem_Rd == 0) drops++;
            else begin
                mValid[1] = 1'b1; mRd[1] = Mem_Rd; mData[1] = Mem_Data; mStamp[1] = mCycle;
            end
        end
        mDrops = (mDrops + drops > 255) ? 255 : mDrops + drops;
        mCycle++;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic compareModel();
        int w;
        logic [31:0] ep;
        w  = modelWinner();
        ep = '0;
        for (int i = 1; i < 32; i++)
            if ((mValid[0] && mRd[0] == i) || (mValid[1] && mRd[1] == i) || (mRegWr && mRw == i))
                ep[i] = 1'b1;
        checkOutput("model RegWr", RegWr, mRegWr);
        checkOutput("model Rw", Rw, mRw);
        checkOutput("model busW", busW, mBusW);
        checkOutput("model Pend", Pend, ep);
        checkOutput("model DropCnt", DropCnt, mDrops);
        checkOutput("model Alu_Ready", Alu_Ready, !mValid[0] || w == 0);
        checkOutput("model Mem_Ready", Mem_Ready, !mValid[1] || w == 1);
    endtask

    // One rising edge for the model, then a falling-edge register-file write and compare.
    task automatic tick();
        @(posedge Clk);
        modelStep();
        @(negedge Clk);
        if (RegWr) rf[Rw] = busW;
        compareModel();
    endtask

    task automatic applyStimulus();
        Run = ($urandom_range(0, 9) != 0);
        if (!(Alu_Valid && !aluTook)) begin
            Alu_Valid = ($urandom_range(0, 2) != 0);
            Alu_Rd    = AW'($urandom_range(0, 7));
            Alu_Data  = $urandom;
            Alu_Ovf   = ($urandom_range(0, 9) == 0);
        end
        if (!(Mem_Valid && !memTook)) begin
            Mem_Valid = ($urandom_range(0, 2) != 0);
            Mem_Rd    = AW'($urandom_range(0, 7));
            Mem_Data  = $urandom;
        end
    endtask

    task automatic idle(input int n);
        Alu_Valid = 1'b0; Mem_Valid = 1'b0; Alu_Ovf = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        modelReset();
        tick();
        tick();
        checkOutput("reset RegWr", RegWr, 1'b0);
        checkOutput("reset Rw", Rw, 0);
        checkOutput("reset busW", busW, 0);
        checkOutput("reset Pend", Pend, 0);
        checkOutput("reset DropCnt", DropCnt, 0);
        checkOutput("reset Alu_Ready", Alu_Ready, 1'b1);
        checkOutput("reset Mem_Ready", Mem_Ready, 1'b1);
        Reset_n = 1'b1;
        tick();

        // Single write latency and scoreboard window
        Alu_Valid = 1'b1; Alu_Rd = 5; Alu_Data = 32'h0000_1234;
        tick();
        checkOutput("single Pend5 e0", Pend[5], 1'b1);
        checkOutput("single RegWr e0", RegWr, 1'b0);
        Alu_Valid = 1'b0;
        tick();
        checkOutput("single RegWr e1", RegWr, 1'b1);
        checkOutput("single Rw e1", Rw, 5);
        checkOutput("single busW e1", busW, 32'h0000_1234);
        checkOutput("single Pend5 e1", Pend[5], 1'b1);
        tick();
        checkOutput("single RegWr e2", RegWr, 1'b0);
        checkOutput("single Pend5 e2", Pend[5], 1'b0);

        // Drops: overflow and $0 in the same edge, then saturation
        Alu_Valid = 1'b1; Alu_Rd = 7; Alu_Ovf = 1'b1;
        Mem_Valid = 1'b1; Mem_Rd = 0;
        tick();
        checkOutput("drop DropCnt", DropCnt, 2);
        checkOutput("drop RegWr", RegWr, 1'b0);
        checkOutput("drop Pend", Pend, 0);
        for (int i = 0; i < 130; i++) tick();
        checkOutput("drop saturate", DropCnt, 255);
        tick();
        checkOutput("drop stay sat", DropCnt, 255);
        idle(2);

        // Conflict with round-robin, ALU favoured first
        Alu_Valid = 1'b1; Alu_Rd = 3; Alu_Data = 32'hA0;
        Mem_Valid = 1'b1; Mem_Rd = 4; Mem_Data = 32'hB0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k >= 1) begin
                checkOutput("rr RegWr", RegWr, 1'b1);
                checkOutput("rr Rw", Rw, (k % 2 == 1) ? 3 : 4);
            end
            if (aluTook) Alu_Data = Alu_Data + 1;
            if (memTook) Mem_Data = Mem_Data + 1;
        end
        idle(3);

        // WAW: ALU then Mem to the same register
        Alu_Valid = 1'b1; Alu_Rd = 9; Alu_Data = 32'hAAAA_0009;
        tick();
        Alu_Valid = 1'b0; Mem_Valid = 1'b1; Mem_Rd = 9; Mem_Data = 32'hBBBB_0009;
        tick();
        checkOutput("waw first busW", busW, 32'hAAAA_0009);
        Mem_Valid = 1'b0;
        tick();
        checkOutput("waw second busW", busW, 32'hBBBB_0009);
        tick();
        checkOutput("waw rf9", rf[9], 32'hBBBB_0009);

        // Age rule: Mem loaded first while frozen must retire first
        Run = 1'b0;
        Mem_Valid = 1'b1; Mem_Rd = 9; Mem_Data = 32'hCCCC_0009;
        tick();
        Mem_Valid = 1'b0; Alu_Valid = 1'b1; Alu_Rd = 9; Alu_Data = 32'hDDDD_0009;
        tick();
        Alu_Valid = 1'b0; Run = 1'b1;
        tick();
        checkOutput("age first busW", busW, 32'hCCCC_0009);
        tick();
        checkOutput("age second busW", busW, 32'hDDDD_0009);
        tick();
        checkOutput("age rf9", rf[9], 32'hDDDD_0009);

        // Run gating with both slots full
        Run = 1'b0;
        Alu_Valid = 1'b1; Alu_Rd = 10; Alu_Data = 32'h1010;
        Mem_Valid = 1'b1; Mem_Rd = 11; Mem_Data = 32'h1111;
        tick();
        Alu_Valid = 1'b0; Mem_Valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("run0 RegWr", RegWr, 1'b0);
            checkOutput("run0 Alu_Ready", Alu_Ready, 1'b0);
            checkOutput("run0 Mem_Ready", Mem_Ready, 1'b0);
        end
        checkOutput("run0 Pend", Pend, 32'h0000_0C00);
        Run = 1'b1;
        tick();
        checkOutput("run1 first RegWr", RegWr, 1'b1);
        tick();
        checkOutput("run1 second RegWr", RegWr, 1'b1);
        tick();
        checkOutput("run1 done RegWr", RegWr, 1'b0);
        checkOutput("run1 rf10", rf[10], 32'h1010);
        checkOutput("run1 rf11", rf[11], 32'h1111);

        // Asynchronous reset with both slots full
        Run = 1'b0;
        Alu_Valid = 1'b1; Alu_Rd = 12; Alu_Data = 32'h1212;
        Mem_Valid = 1'b1; Mem_Rd = 13; Mem_Data = 32'h1313;
        tick();
        Alu_Valid = 1'b0; Mem_Valid = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("areset RegWr", RegWr, 1'b0);
        checkOutput("areset Pend", Pend, 0);
        checkOutput("areset DropCnt", DropCnt, 0);
        checkOutput("areset Alu_Ready", Alu_Ready, 1'b1);
        checkOutput("areset Mem_Ready", Mem_Ready, 1'b1);
        tick();
        Reset_n = 1'b1; Run = 1'b1;
        tick();
        checkOutput("areset no write 1", RegWr, 1'b0);
        tick();
        checkOutput("areset no write 2", RegWr, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            tick();
        end
        Run = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
